// File: rtl/snoop_cache_responder_pkg.sv
// snoop_pkg: shared widths, coherence/bus encodings, FSM state codes,
// cache line layout and result packing for snoop_cache_responder.
package snoop_pkg;

  localparam int TAG_W    = 12;
  localparam int DATA_W   = 16;
  localparam int RESULT_W = 31;

  // Result word layout: {hit, msi_state, tag, data}
  localparam int RES_HIT_BIT   = 30;
  localparam int RES_STATE_LSB = 28;
  localparam int RES_TAG_LSB   = 16;
  localparam int RES_DATA_LSB  = 0;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_e;

  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_WB   = 2'b11
  } bus_op_e;

  // FSM state codes kept as plain constants for older tool flows
  typedef logic [2:0] resp_state_e;
  localparam resp_state_e ST_IDLE      = 3'd0;
  localparam resp_state_e ST_WB_REQ    = 3'd1;
  localparam resp_state_e ST_FILL_REQ  = 3'd2;
  localparam resp_state_e ST_FILL_WAIT = 3'd3;
  localparam resp_state_e ST_RESP      = 3'd4;

  typedef struct packed {
    msi_e              state;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [RESULT_W-1:0] pack_result(
    input logic              hit,
    input msi_e              st,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] data
  );
    logic [RESULT_W-1:0] r;
    r = '0;
    r[RES_HIT_BIT]              = hit;
    r[RES_STATE_LSB +: 2]       = st;
    r[RES_TAG_LSB +: TAG_W]     = tag;
    r[RES_DATA_LSB +: DATA_W]   = data;
    return r;
  endfunction

endpackage

// File: rtl/snoop_cache_responder_if.sv
// snoop_cache_responder_if: CPU request, result, bus and snoop signals of one
// cache controller. The cache uses the slave modport; the CPU/bus side uses master.
interface snoop_cache_responder_if;
  import snoop_pkg::*;

  logic                req_write;
  logic                req_read;
  logic [TAG_W-1:0]    req_tag;
  logic [DATA_W-1:0]   req_data;
  logic                req_ready;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  bus_op_e             bus_op;
  logic [TAG_W-1:0]    bus_tag;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_gnt;
  logic                bus_ack;
  logic [DATA_W-1:0]   bus_rdata;
  bus_op_e             snoop_op;
  logic [TAG_W-1:0]    snoop_tag;
  logic                flush_valid;
  logic [DATA_W-1:0]   flush_data;

  modport slave (
    input  req_write, req_read, req_tag, req_data,
    input  bus_gnt, bus_ack, bus_rdata, snoop_op, snoop_tag,
    output req_ready, result, result_valid,
    output bus_op, bus_tag, bus_wdata, flush_valid, flush_data
  );

  modport master (
    output req_write, req_read, req_tag, req_data,
    output bus_gnt, bus_ack, bus_rdata, snoop_op, snoop_tag,
    input  req_ready, result, result_valid,
    input  bus_op, bus_tag, bus_wdata, flush_valid, flush_data
  );

endinterface

// File: rtl/snoop_cache_responder_cache_line_array.sv
// cache_line_array: LINES x {state, tag, data} storage with one write port
// and two asynchronous read ports (CPU lookup and snoop lookup).
module cache_line_array
  import snoop_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] cpu_idx,
  output line_t            cpu_line,
  input  logic [IDX_W-1:0] snp_idx,
  output line_t            snp_line,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  line_t            w_line
);

  line_t mem [LINES];

  // Single write port; reset invalidates every line and clears tag/data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[w_idx] <= w_line;
    end
  end

  assign cpu_line = mem[cpu_idx];
  assign snp_line = mem[snp_idx];

endmodule

// File: rtl/snoop_cache_responder.sv
// snoop_cache_responder: per-CPU direct-mapped MSI cache controller.
// Serves CPU requests, issues BUSRD/BUSRDX/BUSWB on misses and upgrades,
// and snoops other caches' bus ops every cycle (snoop has write priority).
// Optional macro SNOOP_STATS_EN adds saturating hit/miss/invalidate counters.
module snoop_cache_responder
  import snoop_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic clock,
  input  logic reset_n,
  snoop_cache_responder_if.slave io
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [15:0] inval_cnt
`endif
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  resp_state_e         state;
  logic                lat_write;
  logic                upgrade;
  logic                have_data;
  logic [TAG_W-1:0]    lat_tag;
  logic [TAG_W-1:0]    victim_tag;
  logic [DATA_W-1:0]   lat_data;
  logic [DATA_W-1:0]   victim_data;
  logic [RESULT_W-1:0] result_q;
  logic                flush_valid_q;
  logic [DATA_W-1:0]   flush_data_q;

  logic [IDX_W-1:0]  cpu_idx;
  logic [IDX_W-1:0]  snp_idx;
  logic [IDX_W-1:0]  w_idx;
  line_t             cpu_line;
  line_t             snp_line;
  line_t             snp_new_line;
  line_t             commit_line;
  line_t             w_line;
  logic              we;
  logic              snp_we;
  logic              snp_flush;
  logic              snp_inval_ours;
  logic              cpu_hit;
  logic              accept;
  logic              commit_want;
  logic              commit_done;
  logic [DATA_W-1:0] fill_data;

  assign cpu_idx      = io.req_tag[IDX_W-1:0];
  assign snp_idx      = io.snoop_tag[IDX_W-1:0];
  assign cpu_hit      = (cpu_line.state != MSI_I) && (cpu_line.tag == io.req_tag);
  assign io.req_ready = (state == ST_IDLE) && (io.snoop_op == BUS_NONE);
  assign accept       = io.req_ready && (io.req_write || io.req_read);

  cache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_lines (
    .clock    (clock),
    .reset_n  (reset_n),
    .cpu_idx  (cpu_idx),
    .cpu_line (cpu_line),
    .snp_idx  (snp_idx),
    .snp_line (snp_line),
    .we       (we),
    .w_idx    (w_idx),
    .w_line   (w_line)
  );

  // Snoop response: BUSRD on M downgrades to S with a flush, BUSRDX invalidates
  always_comb begin
    snp_we       = 1'b0;
    snp_flush    = 1'b0;
    snp_new_line = snp_line;
    if ((snp_line.state != MSI_I) && (snp_line.tag == io.snoop_tag)) begin
      if ((io.snoop_op == BUS_RD) && (snp_line.state == MSI_M)) begin
        snp_we             = 1'b1;
        snp_flush          = 1'b1;
        snp_new_line.state = MSI_S;
      end else if (io.snoop_op == BUS_RDX) begin
        snp_we             = 1'b1;
        snp_flush          = (snp_line.state == MSI_M);
        snp_new_line.state = MSI_I;
      end
    end
  end

  assign snp_inval_ours = snp_we && (snp_new_line.state == MSI_I) && (io.snoop_tag == lat_tag);
  assign fill_data      = (have_data || lat_write) ? lat_data : io.bus_rdata;

  // Local line update wanted by the FSM this cycle (write hit, upgrade grant, fill)
  always_comb begin
    commit_want = 1'b0;
    commit_line = '{MSI_M, lat_tag, lat_data};
    case (state)
      ST_IDLE: begin
        if (accept && cpu_hit && io.req_write && (cpu_line.state == MSI_M)) begin
          commit_want = 1'b1;
          commit_line = '{MSI_M, io.req_tag, io.req_data};
        end
      end
      ST_FILL_REQ: commit_want = io.bus_gnt && upgrade && !snp_inval_ours;
      ST_FILL_WAIT: begin
        commit_want = have_data || io.bus_ack;
        commit_line = '{(lat_write ? MSI_M : MSI_S), lat_tag, fill_data};
      end
      default: commit_want = 1'b0;
    endcase
  end

  // A snoop update owns the write port; a displaced local update is retried
  assign commit_done = commit_want && !snp_we;
  assign we          = snp_we || commit_want;
  assign w_idx       = snp_we ? snp_idx : commit_line.tag[IDX_W-1:0];
  assign w_line      = snp_we ? snp_new_line : commit_line;

  // Bus request decode: held constant for the whole WB_REQ / FILL_REQ stay
  always_comb begin
    io.bus_op    = BUS_NONE;
    io.bus_tag   = '0;
    io.bus_wdata = '0;
    case (state)
      ST_WB_REQ: begin
        io.bus_op    = BUS_WB;
        io.bus_tag   = victim_tag;
        io.bus_wdata = victim_data;
      end
      ST_FILL_REQ: begin
        io.bus_op  = lat_write ? BUS_RDX : BUS_RD;
        io.bus_tag = lat_tag;
      end
      default: io.bus_op = BUS_NONE;
    endcase
  end

  assign io.result       = result_q;
  assign io.result_valid = (state == ST_RESP);
  assign io.flush_valid  = flush_valid_q;
  assign io.flush_data   = flush_data_q;

  // Request FSM, latched request/victim, result register and flush pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      lat_write     <= 1'b0;
      upgrade       <= 1'b0;
      have_data     <= 1'b0;
      lat_tag       <= '0;
      lat_data      <= '0;
      victim_tag    <= '0;
      victim_data   <= '0;
      result_q      <= '0;
      flush_valid_q <= 1'b0;
      flush_data_q  <= '0;
    end else begin
      flush_valid_q <= snp_flush;
      if (snp_flush) flush_data_q <= snp_line.data;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write <= io.req_write;
            lat_tag   <= io.req_tag;
            lat_data  <= io.req_data;
            have_data <= 1'b0;
            upgrade   <= 1'b0;
            if (cpu_hit) begin
              if (!io.req_write) begin
                state    <= ST_RESP;
                result_q <= pack_result(1'b1, cpu_line.state, cpu_line.tag, cpu_line.data);
              end else if (cpu_line.state == MSI_M) begin
                state    <= ST_RESP;
                result_q <= pack_result(1'b1, MSI_M, io.req_tag, io.req_data);
              end else begin
                state   <= ST_FILL_REQ;
                upgrade <= 1'b1;
              end
            end else begin
              victim_tag  <= cpu_line.tag;
              victim_data <= cpu_line.data;
              state       <= (cpu_line.state == MSI_M) ? ST_WB_REQ : ST_FILL_REQ;
            end
          end
        end
        ST_WB_REQ: begin
          if (io.bus_gnt) state <= ST_FILL_REQ;
        end
        ST_FILL_REQ: begin
          if (io.bus_gnt) begin
            if (upgrade && !snp_inval_ours) begin
              if (commit_done) begin
                state    <= ST_RESP;
                result_q <= pack_result(1'b1, MSI_M, lat_tag, lat_data);
              end else begin
                state     <= ST_FILL_WAIT;
                have_data <= 1'b1;
              end
            end else begin
              state   <= ST_FILL_WAIT;
              upgrade <= 1'b0;
            end
          end else if (snp_inval_ours) begin
            upgrade <= 1'b0;
          end
        end
        ST_FILL_WAIT: begin
          if (have_data || io.bus_ack) begin
            if (commit_done) begin
              state     <= ST_RESP;
              have_data <= 1'b0;
              result_q  <= pack_result(upgrade, commit_line.state, lat_tag, fill_data);
            end else begin
              have_data <= 1'b1;
              lat_data  <= fill_data;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SNOOP_STATS_EN
  // Saturating statistics: accepted hits/misses and snoop-caused invalidations
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      inval_cnt <= '0;
    end else begin
      if (accept && cpu_hit && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if (accept && !cpu_hit && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      if (snp_we && (snp_new_line.state == MSI_I) && (inval_cnt != 16'hFFFF))
        inval_cnt <= inval_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_cache_responder.sv
// tb_snoop_cache_responder: directed self-checking bench for snoop_cache_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_snoop_cache_responder;
  import snoop_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  snoop_cache_responder_if io ();

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] inval_cnt;
`endif

  snoop_cache_responder #(.LINES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
`ifdef SNOOP_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .inval_cnt (inval_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: sequence did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expRes(input logic hit, input logic [1:0] st,
                                         input logic [11:0] tag, input logic [15:0] data);
    return {1'b0, hit, st, tag, data};
  endfunction

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [11:0] tag, input logic [15:0] data);
    io.req_write = wr;
    io.req_read  = rd;
    io.req_tag   = tag;
    io.req_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    io.bus_gnt   = 1'b0;
    io.bus_ack   = 1'b0;
    io.bus_rdata = 16'h0000;
    io.snoop_op  = BUS_NONE;
    io.snoop_tag = 12'h000;
    repeat (2) @(negedge clock);

    $display("[TB] reset values");
    checkOutput("rst_result", 32'(io.result), 32'h0);
    checkOutput("rst_result_valid", 32'(io.result_valid), 32'h0);
    checkOutput("rst_bus_op", 32'(io.bus_op), 32'(BUS_NONE));
    checkOutput("rst_bus_tag", 32'(io.bus_tag), 32'h0);
    checkOutput("rst_bus_wdata", 32'(io.bus_wdata), 32'h0);
    checkOutput("rst_flush_valid", 32'(io.flush_valid), 32'h0);
    checkOutput("rst_flush_data", 32'(io.flush_data), 32'h0);
    checkOutput("rst_req_ready", 32'(io.req_ready), 32'h1);
    reset_n = 1'b1;

    $display("[TB] read miss 005 fill BEEF");
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    #1 checkOutput("t1_req_ready", 32'(io.req_ready), 32'h1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t1_bus_op", 32'(io.bus_op), 32'(BUS_RD));
    checkOutput("t1_bus_tag", 32'(io.bus_tag), 32'h005);
    checkOutput("t1_no_early_valid", 32'(io.result_valid), 32'h0);
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt = 1'b0;
    checkOutput("t1_bus_op_after_gnt", 32'(io.bus_op), 32'(BUS_NONE));
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'hBEEF;
    @(negedge clock);
    io.bus_ack = 1'b0;
    checkOutput("t1_valid", 32'(io.result_valid), 32'h1);
    checkOutput("t1_result", 32'(io.result), expRes(1'b0, 2'b01, 12'h005, 16'hBEEF));
    @(negedge clock);
    checkOutput("t1_valid_pulse", 32'(io.result_valid), 32'h0);

    $display("[TB] read hit 005");
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t2_valid", 32'(io.result_valid), 32'h1);
    checkOutput("t2_result", 32'(io.result), expRes(1'b1, 2'b01, 12'h005, 16'hBEEF));
    checkOutput("t2_bus_op", 32'(io.bus_op), 32'(BUS_NONE));
    @(negedge clock);

    $display("[TB] write hit S upgrade 005");
    applyStimulus(1'b1, 1'b0, 12'h005, 16'h1234);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t3_bus_op", 32'(io.bus_op), 32'(BUS_RDX));
    checkOutput("t3_bus_tag", 32'(io.bus_tag), 32'h005);
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt = 1'b0;
    checkOutput("t3_valid", 32'(io.result_valid), 32'h1);
    checkOutput("t3_result", 32'(io.result), expRes(1'b1, 2'b10, 12'h005, 16'h1234));
    checkOutput("t3_bus_op_after", 32'(io.bus_op), 32'(BUS_NONE));
    @(negedge clock);

    $display("[TB] snoop BUSRD on M line");
    io.snoop_op  = BUS_RD;
    io.snoop_tag = 12'h005;
    #1 checkOutput("t4_req_ready_snoop", 32'(io.req_ready), 32'h0);
    @(negedge clock);
    io.snoop_op = BUS_NONE;
    checkOutput("t4_flush_valid", 32'(io.flush_valid), 32'h1);
    checkOutput("t4_flush_data", 32'(io.flush_data), 32'h1234);
    @(negedge clock);
    checkOutput("t4_flush_pulse", 32'(io.flush_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t4_line_now_s", 32'(io.result), expRes(1'b1, 2'b01, 12'h005, 16'h1234));
    @(negedge clock);

    $display("[TB] make line 1 M with tag 001, then read 005");
    applyStimulus(1'b1, 1'b0, 12'h001, 16'hABCD);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t5_wmiss_bus_op", 32'(io.bus_op), 32'(BUS_RDX));
    checkOutput("t5_wmiss_bus_tag", 32'(io.bus_tag), 32'h001);
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt   = 1'b0;
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'h0F0F;
    @(negedge clock);
    io.bus_ack = 1'b0;
    checkOutput("t5_wmiss_result", 32'(io.result), expRes(1'b0, 2'b10, 12'h001, 16'hABCD));
    @(negedge clock);
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t5_wb_op", 32'(io.bus_op), 32'(BUS_WB));
    checkOutput("t5_wb_tag", 32'(io.bus_tag), 32'h001);
    checkOutput("t5_wb_data", 32'(io.bus_wdata), 32'hABCD);
    @(negedge clock);
    checkOutput("t5_wb_held", 32'(io.bus_op), 32'(BUS_WB));
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt = 1'b0;
    checkOutput("t5_rd_op", 32'(io.bus_op), 32'(BUS_RD));
    checkOutput("t5_rd_tag", 32'(io.bus_tag), 32'h005);
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt   = 1'b0;
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'h5555;
    @(negedge clock);
    io.bus_ack = 1'b0;
    checkOutput("t5_result", 32'(io.result), expRes(1'b0, 2'b01, 12'h005, 16'h5555));
    @(negedge clock);

    $display("[TB] snoop BUSRDX collides with local read");
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    io.snoop_op  = BUS_RDX;
    io.snoop_tag = 12'h005;
    #1 checkOutput("t6_req_ready", 32'(io.req_ready), 32'h0);
    @(negedge clock);
    io.snoop_op = BUS_NONE;
    #1;
    checkOutput("t6_no_flush_s", 32'(io.flush_valid), 32'h0);
    checkOutput("t6_not_accepted", 32'(io.result_valid), 32'h0);
    checkOutput("t6_req_ready_after", 32'(io.req_ready), 32'h1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t6_miss_op", 32'(io.bus_op), 32'(BUS_RD));
    checkOutput("t6_miss_tag", 32'(io.bus_tag), 32'h005);
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt   = 1'b0;
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'h7777;
    reset_n      = 1'b0;
    #1;
    checkOutput("t6_rst_bus_op", 32'(io.bus_op), 32'(BUS_NONE));
    checkOutput("t6_rst_result", 32'(io.result), 32'h0);
    checkOutput("t6_rst_valid", 32'(io.result_valid), 32'h0);
    checkOutput("t6_rst_flush_data", 32'(io.flush_data), 32'h0);
    checkOutput("t6_rst_req_ready", 32'(io.req_ready), 32'h1);
    @(negedge clock);
    io.bus_ack = 1'b0;
    reset_n    = 1'b1;
    applyStimulus(1'b0, 1'b1, 12'h005, 16'h0000);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t6_still_miss", 32'(io.bus_op), 32'(BUS_RD));
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt   = 1'b0;
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'h9999;
    @(negedge clock);
    io.bus_ack = 1'b0;
    checkOutput("t6_refill_result", 32'(io.result), expRes(1'b0, 2'b01, 12'h005, 16'h9999));
    @(negedge clock);

    $display("[TB] snoop invalidates line during upgrade");
    applyStimulus(1'b1, 1'b0, 12'h005, 16'h4321);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000);
    checkOutput("t7_upg_op", 32'(io.bus_op), 32'(BUS_RDX));
    io.snoop_op  = BUS_RDX;
    io.snoop_tag = 12'h005;
    @(negedge clock);
    io.snoop_op = BUS_NONE;
    checkOutput("t7_op_held", 32'(io.bus_op), 32'(BUS_RDX));
    io.bus_gnt = 1'b1;
    @(negedge clock);
    io.bus_gnt = 1'b0;
    checkOutput("t7_waits_fill", 32'(io.result_valid), 32'h0);
    checkOutput("t7_op_none", 32'(io.bus_op), 32'(BUS_NONE));
    io.bus_ack   = 1'b1;
    io.bus_rdata = 16'h0000;
    @(negedge clock);
    io.bus_ack = 1'b0;
    checkOutput("t7_valid", 32'(io.result_valid), 32'h1);
    checkOutput("t7_result", 32'(io.result), expRes(1'b0, 2'b10, 12'h005, 16'h4321));
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
